// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe game controller:
//   - move command codes presented on the 'move' port
//   - display colour codes (defaults for the controller's colour parameters)
//   - 2-bit board cell encoding (also used as the player / winner encoding)
//   - FSM state codes
//   - helpers for cell indexing, display-word packing and line membership
// Cells are indexed row-major: index = row*3 + col, (c0,r0) is index 0.
// ---------------------------------------------------------------------------
package ttt_pkg;

    // Command codes
    localparam logic [2:0] MV_UP    = 3'b000;
    localparam logic [2:0] MV_LEFT  = 3'b001;
    localparam logic [2:0] MV_DOWN  = 3'b010;
    localparam logic [2:0] MV_RIGHT = 3'b011;
    localparam logic [2:0] MV_PLACE = 3'b100;
    localparam logic [2:0] MV_NONE  = 3'b111;

    // Colour codes
    localparam logic [2:0] COL_BLANK  = 3'b000;
    localparam logic [2:0] COL_RED    = 3'b001;
    localparam logic [2:0] COL_BLUE   = 3'b010;
    localparam logic [2:0] COL_GREEN  = 3'b011;
    localparam logic [2:0] COL_CYAN   = 3'b101;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    // Cell contents; the same codes identify the player and the winner
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_CLEAR     = 3'd0;
    localparam state_t ST_PAINT_CUR = 3'd1;
    localparam state_t ST_IDLE      = 3'd2;
    localparam state_t ST_RESTORE   = 3'd3;
    localparam state_t ST_PAINT     = 3'd4;
    localparam state_t ST_CHECK     = 3'd5;
    localparam state_t ST_WIN_PAINT = 3'd6;
    localparam state_t ST_DONE      = 3'd7;

    // Row-major cell index of (col,row)
    function automatic logic [3:0] cell_index(input logic [1:0] col, input logic [1:0] row);
        return 4'(row) * 4'd3 + 4'(col);
    endfunction

    function automatic logic [1:0] cell_col(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] cell_row(input logic [3:0] idx);
        if (idx < 4'd3) begin
            return 2'd0;
        end else if (idx < 4'd6) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    // Display write word: [7:6] column, [5:4] row, [2:0] colour, rest zero
    function automatic logic [31:0] make_target(input logic [1:0] col, input logic [1:0] row,
                                                input logic [2:0] colour);
        return {24'd0, col, row, 1'b0, colour};
    endfunction

    // k-th cell (k = 0..2, ascending index) of line 'line':
    // lines 0-2 are rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
    function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] k);
        case (line)
            3'd0, 3'd1, 3'd2: return 4'(line) * 4'd3 + 4'(k);
            3'd3, 3'd4, 3'd5: return 4'(line - 3'd3) + 4'(k) * 4'd3;
            3'd6:             return 4'(k) * 4'd4;
            default:          return 4'd2 + 4'(k) * 4'd2;
        endcase
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// ---------------------------------------------------------------------------
// ttt_win_check
// Combinational three-in-a-row detector for one player.
// Ports:
//   board  [17:0] in  : cell i occupies bits [2i+1:2i], 00 empty / 01 P1 / 10 P2
//   player [1:0]  in  : player code to test (01 or 10)
//   hit           out : at least one line is fully owned by 'player'
//   line   [2:0]  out : lowest-numbered winning line (0 when hit is low)
// ---------------------------------------------------------------------------
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        hit,
    output logic [2:0]  line
);

    logic [7:0] line_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            localparam int C0 = int'(line_cell(3'(gi), 2'd0));
            localparam int C1 = int'(line_cell(3'(gi), 2'd1));
            localparam int C2 = int'(line_cell(3'(gi), 2'd2));
            assign line_hit[gi] = (board[2*C0 +: 2] == player) &&
                                  (board[2*C1 +: 2] == player) &&
                                  (board[2*C2 +: 2] == player);
        end
    endgenerate

    // Scan from the top so the lowest-numbered hit is the one left standing.
    always_comb begin
        hit  = |line_hit;
        line = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (line_hit[i]) begin
                line = 3'(i);
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Two-player tic-tac-toe controller driving a cell-addressed display.
// Ports:
//   CLK               in  : clock, rising edge
//   rst               in  : synchronous active-high reset
//   move       [2:0]  in  : command (up/left/right/down/place/none)
//   new_button        in  : command pending, held until move_ready
//   move_ready        out : one-cycle acknowledge of new_button
//   target     [31:0] out : display write {col[7:6], row[5:4], colour[2:0]}
//   target_save       out : one-cycle strobe qualifying target
//   game_over         out : game finished (win or draw)
//   winner     [1:0]  out : 00 none/draw, 01 player 1, 10 player 2
// All outputs are registered. target is zero whenever target_save is low.
// ---------------------------------------------------------------------------
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [2:0] P1_COLOR      = COL_RED,
    parameter logic [2:0] P2_COLOR      = COL_BLUE,
    parameter logic [2:0] CUR_COLOR     = COL_GREEN,
    parameter logic [2:0] CUR_OCC_COLOR = COL_YELLOW,
    parameter logic [2:0] WIN_COLOR     = COL_CYAN
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [2:0]  move,
    input  logic        new_button,
    output logic        move_ready,
    output logic [31:0] target,
    output logic        target_save,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t      state_reg;
    logic [17:0] board_reg;
    logic [1:0]  col_reg;
    logic [1:0]  row_reg;
    logic [1:0]  dcol_reg;       // cursor destination, committed in RESTORE
    logic [1:0]  drow_reg;
    logic [1:0]  player_reg;
    logic [3:0]  count_reg;
    logic        armed_reg;
    logic [3:0]  step_reg;       // cell counter for CLEAR and WIN_PAINT
    logic [2:0]  win_line_reg;
    logic        move_ready_reg;
    logic [31:0] target_reg;
    logic        target_save_reg;
    logic        game_over_reg;
    logic [1:0]  winner_reg;

    logic [3:0]  cur_idx;
    logic [1:0]  cur_cell;
    logic [3:0]  win_cell;
    logic        win_hit;
    logic [2:0]  win_line;
    logic        ack_ok;

    assign cur_idx  = cell_index(col_reg, row_reg);
    assign cur_cell = board_reg[{cur_idx, 1'b0} +: 2];
    assign win_cell = line_cell(win_line_reg, step_reg[1:0]);
    // Never acknowledge on two consecutive cycles.
    assign ack_ok   = new_button && !move_ready_reg;

    ttt_win_check u_win_check (
        .board  (board_reg),
        .player (player_reg),
        .hit    (win_hit),
        .line   (win_line)
    );

    function automatic logic [2:0] mark_colour(input logic [1:0] mark);
        case (mark)
            CELL_P1: return P1_COLOR;
            CELL_P2: return P2_COLOR;
            default: return COL_BLANK;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg       <= ST_CLEAR;
            board_reg       <= '0;
            col_reg         <= 2'd1;
            row_reg         <= 2'd1;
            dcol_reg        <= 2'd1;
            drow_reg        <= 2'd1;
            player_reg      <= CELL_P1;
            count_reg       <= 4'd0;
            armed_reg       <= 1'b0;
            step_reg        <= 4'd0;
            win_line_reg    <= 3'd0;
            move_ready_reg  <= 1'b0;
            target_reg      <= 32'd0;
            target_save_reg <= 1'b0;
            game_over_reg   <= 1'b0;
            winner_reg      <= CELL_EMPTY;
        end else begin
            // Strobes default low; target is only non-zero with its strobe.
            move_ready_reg  <= 1'b0;
            target_save_reg <= 1'b0;
            target_reg      <= 32'd0;

            case (state_reg)
                ST_CLEAR: begin
                    target_save_reg <= 1'b1;
                    target_reg      <= make_target(cell_col(step_reg), cell_row(step_reg), COL_BLANK);
                    if (step_reg == 4'd8) begin
                        step_reg  <= 4'd0;
                        state_reg <= ST_PAINT_CUR;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end

                ST_PAINT_CUR: begin
                    target_save_reg <= 1'b1;
                    target_reg      <= make_target(col_reg, row_reg, CUR_COLOR);
                    state_reg       <= ST_IDLE;
                end

                ST_IDLE: begin
                    // The command is sampled on the acknowledge edge itself.
                    if (ack_ok) begin
                        move_ready_reg <= 1'b1;
                        if (armed_reg && move != MV_NONE) begin
                            armed_reg <= 1'b0;
                            dcol_reg  <= col_reg;
                            drow_reg  <= row_reg;
                            case (move)
                                MV_UP: begin
                                    if (row_reg != 2'd0) begin
                                        drow_reg  <= row_reg - 2'd1;
                                        state_reg <= ST_RESTORE;
                                    end
                                end
                                MV_DOWN: begin
                                    if (row_reg != 2'd2) begin
                                        drow_reg  <= row_reg + 2'd1;
                                        state_reg <= ST_RESTORE;
                                    end
                                end
                                MV_LEFT: begin
                                    if (col_reg != 2'd0) begin
                                        dcol_reg  <= col_reg - 2'd1;
                                        state_reg <= ST_RESTORE;
                                    end
                                end
                                MV_RIGHT: begin
                                    if (col_reg != 2'd2) begin
                                        dcol_reg  <= col_reg + 2'd1;
                                        state_reg <= ST_RESTORE;
                                    end
                                end
                                MV_PLACE: begin
                                    if (cur_cell == CELL_EMPTY) begin
                                        board_reg[{cur_idx, 1'b0} +: 2] <= player_reg;
                                        count_reg <= count_reg + 4'd1;
                                        state_reg <= ST_CHECK;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                ST_RESTORE: begin
                    // Repaint the cell the cursor leaves with its mark colour.
                    // After a drawing move the destination equals the cursor,
                    // so this write is the last mark and the game then ends.
                    target_save_reg <= 1'b1;
                    target_reg      <= make_target(col_reg, row_reg, mark_colour(cur_cell));
                    col_reg         <= dcol_reg;
                    row_reg         <= drow_reg;
                    state_reg       <= game_over_reg ? ST_DONE : ST_PAINT;
                end

                ST_PAINT: begin
                    target_save_reg <= 1'b1;
                    target_reg      <= make_target(col_reg, row_reg,
                                                   (cur_cell == CELL_EMPTY) ? CUR_COLOR : CUR_OCC_COLOR);
                    state_reg       <= ST_IDLE;
                end

                ST_CHECK: begin
                    if (win_hit) begin
                        winner_reg    <= player_reg;
                        game_over_reg <= 1'b1;
                        win_line_reg  <= win_line;
                        step_reg      <= 4'd0;
                        state_reg     <= ST_WIN_PAINT;
                    end else if (count_reg == 4'd9) begin
                        winner_reg    <= CELL_EMPTY;
                        game_over_reg <= 1'b1;
                        state_reg     <= ST_RESTORE;
                    end else begin
                        player_reg <= (player_reg == CELL_P1) ? CELL_P2 : CELL_P1;
                        state_reg  <= ST_PAINT;
                    end
                end

                ST_WIN_PAINT: begin
                    target_save_reg <= 1'b1;
                    target_reg      <= make_target(cell_col(win_cell), cell_row(win_cell), WIN_COLOR);
                    if (step_reg == 4'd2) begin
                        step_reg  <= 4'd0;
                        state_reg <= ST_DONE;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end

                ST_DONE: begin
                    if (ack_ok) begin
                        move_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_CLEAR;
                end
            endcase

            // Releasing the keys re-arms command execution.
            if (move == MV_NONE) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign move_ready  = move_ready_reg;
    assign target      = target_reg;
    assign target_save = target_save_reg;
    assign game_over   = game_over_reg;
    assign winner      = winner_reg;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

    logic        CLK = 1'b0;
    logic        rst;
    logic [2:0]  move;
    logic        new_button;
    logic        move_ready;
    logic [31:0] target;
    logic        target_save;
    logic        game_over;
    logic [1:0]  winner;

    always #5 CLK = ~CLK;

    ttt_game_ctrl dut (
        .CLK         (CLK),
        .rst         (rst),
        .move        (move),
        .new_button  (new_button),
        .move_ready  (move_ready),
        .target      (target),
        .target_save (target_save),
        .game_over   (game_over),
        .winner      (winner)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] wq[$];
    int          wcyc[$];
    logic [31:0] exp_w[$];
    int          acks = 0;
    bit          prev_ack = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    always @(posedge CLK) cyc++;

    // Write capture and per-cycle output sanity
    always @(negedge CLK) begin
        if (target_save) begin
            wq.push_back(target);
            wcyc.push_back(cyc);
        end else begin
            check("idle_target_zero", target, 32'd0);
        end
        if (prev_ack) check("ack_not_consecutive", {31'd0, move_ready}, 32'd0);
        if (move_ready) acks++;
        prev_ack = move_ready;
    end

    // ---------------- reference model ----------------
    int mb[9];
    int mcx, mcy, mpl, mcnt, mwin;
    bit marm, mover;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [31:0] tg(input int x, input int y, input int c);
        return 32'((x << 6) | (y << 4) | c);
    endfunction

    function automatic int mark_col(input int m);
        return (m == 1) ? 1 : (m == 2) ? 2 : 0;
    endfunction

    function automatic void model_reset();
        foreach (mb[i]) mb[i] = 0;
        mcx = 1; mcy = 1; mpl = 1; mcnt = 0; mwin = 0;
        marm = 1'b1;     // keys are released (111) throughout the clear
        mover = 1'b0;
    endfunction

    function automatic void model_cmd(input logic [2:0] code, input bit rearm);
        int nx, ny, i, wl, idx;
        exp_w.delete();
        if (rearm) marm = 1'b1;
        if (mover || !marm) return;
        marm = 1'b0;
        nx = mcx; ny = mcy;
        case (code)
            3'b000: if (ny > 0) ny--;
            3'b010: if (ny < 2) ny++;
            3'b001: if (nx > 0) nx--;
            3'b011: if (nx < 2) nx++;
            3'b100: begin
                i = mcy * 3 + mcx;
                if (mb[i] == 0) begin
                    mb[i] = mpl;
                    mcnt++;
                    wl = -1;
                    for (int l = 7; l >= 0; l--)
                        if (mb[lines[l][0]] == mpl && mb[lines[l][1]] == mpl && mb[lines[l][2]] == mpl)
                            wl = l;
                    if (wl >= 0) begin
                        mover = 1'b1; mwin = mpl;
                        for (int k = 0; k < 3; k++) begin
                            idx = lines[wl][k];
                            exp_w.push_back(tg(idx % 3, idx / 3, 5));
                        end
                    end else if (mcnt == 9) begin
                        mover = 1'b1; mwin = 0;
                        exp_w.push_back(tg(mcx, mcy, mark_col(mpl)));
                    end else begin
                        mpl = 3 - mpl;
                        exp_w.push_back(tg(mcx, mcy, 6));
                    end
                end
            end
            default: ;
        endcase
        if (code != 3'b100 && (nx != mcx || ny != mcy)) begin
            exp_w.push_back(tg(mcx, mcy, mark_col(mb[mcy * 3 + mcx])));
            mcx = nx; mcy = ny;
            exp_w.push_back(tg(mcx, mcy, (mb[mcy * 3 + mcx] == 0) ? 3 : 6));
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [2:0] code, input bit rearm);
        int n;
        if (rearm) begin
            move = 3'b111;
            repeat (2) @(negedge CLK);
        end
        wq.delete(); wcyc.delete(); acks = 0;
        move = code;
        new_button = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!move_ready && n < 20);
        check("ack_seen", {31'd0, move_ready}, 32'd1);
        new_button = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic expect_result(input string tag, input bit eo, input logic [1:0] ewin);
        check({tag, " acks"}, 32'(acks), 32'd1);
        check({tag, " nwrites"}, 32'(wq.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
            check($sformatf("%s write%0d", tag, i), wq[i], exp_w[i]);
        check({tag, " game_over"}, {31'd0, game_over}, {31'd0, eo});
        check({tag, " winner"}, {30'd0, winner}, {30'd0, ewin});
        $display("cmd %s: acks=%0d writes=%0d game_over=%0b winner=%0d", tag, acks, wq.size(), game_over, winner);
    endtask

    task automatic step(input logic [2:0] code, input bit rearm, input string tag);
        model_cmd(code, rearm);
        press(code, rearm);
        expect_result(tag, mover, 2'(mwin));
    endtask

    task automatic goto(input int x, input int y, input string tag);
        while (mcx != x) step((mcx < x) ? 3'b011 : 3'b001, 1'b1, tag);
        while (mcy != y) step((mcy < y) ? 3'b010 : 3'b000, 1'b1, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " target_save"}, {31'd0, target_save}, 32'd0);
        check({tag, " target"}, target, 32'd0);
        check({tag, " move_ready"}, {31'd0, move_ready}, 32'd0);
        check({tag, " game_over"}, {31'd0, game_over}, 32'd0);
        check({tag, " winner"}, {30'd0, winner}, 32'd0);
    endtask

    task automatic reset_and_clear(input string tag);
        int start;
        logic [31:0] e;
        move = 3'b111; new_button = 1'b0; rst = 1'b1;
        @(negedge CLK);
        check_reset_outputs({tag, " in_reset"});
        @(negedge CLK);
        wq.delete(); wcyc.delete();
        start = cyc;
        rst = 1'b0;
        repeat (14) @(negedge CLK);
        check({tag, " clear_nwrites"}, 32'(wq.size()), 32'd10);
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            e = (i < 9) ? tg(i % 3, i / 3, 0) : 32'h53;
            check($sformatf("%s clear_w%0d", tag, i), wq[i], e);
            check($sformatf("%s clear_cyc%0d", tag, i), 32'(wcyc[i] - start), 32'(i + 1));
        end
        $display("reset %s: writes=%0d", tag, wq.size());
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  code;
        bit          rearm;
        int          nw;
        logic [31:0] w0, w1, w2;
        bit          over;
        logic [1:0]  win;
    } vec_t;
    vec_t vt[$];

    function automatic void add_vec(input logic [2:0] code, input bit rearm, input int nw,
                                    input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                    input bit over, input logic [1:0] win);
        vec_t v;
        v.code = code; v.rearm = rearm; v.nw = nw;
        v.w0 = w0; v.w1 = w1; v.w2 = w2; v.over = over; v.win = win;
        vt.push_back(v);
    endfunction

    initial begin
        int n;
        int xs[9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
        int ys[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        logic [2:0] codes[6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b100};
        logic [2:0] c;
        bit r;
        int extra;

        rst = 1'b1; move = 3'b111; new_button = 1'b0;

        //          code    rearm nw  w0     w1     w2    over win
        add_vec(3'b011, 1, 2, 32'h50, 32'h93, 32'h0, 0, 2'd0); // right (1,1)->(2,1)
        add_vec(3'b011, 0, 0, 32'h0,  32'h0,  32'h0, 0, 2'd0); // held key ignored
        add_vec(3'b011, 1, 0, 32'h0,  32'h0,  32'h0, 0, 2'd0); // saturated at col 2
        add_vec(3'b000, 1, 2, 32'h90, 32'h83, 32'h0, 0, 2'd0); // up -> (2,0)
        add_vec(3'b100, 1, 1, 32'h86, 32'h0,  32'h0, 0, 2'd0); // P1 at (2,0)
        add_vec(3'b001, 1, 2, 32'h81, 32'h43, 32'h0, 0, 2'd0); // left -> (1,0)
        add_vec(3'b010, 1, 2, 32'h40, 32'h53, 32'h0, 0, 2'd0); // down -> (1,1)
        add_vec(3'b100, 1, 1, 32'h56, 32'h0,  32'h0, 0, 2'd0); // P2 at (1,1)
        add_vec(3'b100, 1, 0, 32'h0,  32'h0,  32'h0, 0, 2'd0); // occupied, ignored
        add_vec(3'b000, 1, 2, 32'h52, 32'h43, 32'h0, 0, 2'd0); // up -> (1,0)
        add_vec(3'b100, 1, 1, 32'h46, 32'h0,  32'h0, 0, 2'd0); // P1 at (1,0)
        add_vec(3'b010, 1, 2, 32'h41, 32'h56, 32'h0, 0, 2'd0); // down onto occupied
        add_vec(3'b001, 1, 2, 32'h52, 32'h13, 32'h0, 0, 2'd0); // left -> (0,1)
        add_vec(3'b100, 1, 1, 32'h16, 32'h0,  32'h0, 0, 2'd0); // P2 at (0,1)
        add_vec(3'b000, 1, 2, 32'h12, 32'h03, 32'h0, 0, 2'd0); // up -> (0,0)
        add_vec(3'b100, 1, 3, 32'h05, 32'h45, 32'h85, 1, 2'd1); // P1 wins row 0
        add_vec(3'b011, 1, 0, 32'h0,  32'h0,  32'h0, 1, 2'd1); // after game: ack only
        add_vec(3'b100, 1, 0, 32'h0,  32'h0,  32'h0, 1, 2'd1);

        reset_and_clear("power_on");
        foreach (vt[i]) begin
            exp_w.delete();
            if (vt[i].nw > 0) exp_w.push_back(vt[i].w0);
            if (vt[i].nw > 1) exp_w.push_back(vt[i].w1);
            if (vt[i].nw > 2) exp_w.push_back(vt[i].w2);
            press(vt[i].code, vt[i].rearm);
            expect_result($sformatf("vec%0d", i), vt[i].over, vt[i].win);
        end

        // Draw: X O X / X O O / O X X
        reset_and_clear("draw");
        for (int i = 0; i < 9; i++) begin
            goto(xs[i], ys[i], "draw_nav");
            step(3'b100, 1'b1, "draw_place");
        end
        check("draw game_over", {31'd0, game_over}, 32'd1);
        check("draw winner", {30'd0, winner}, 32'd0);
        check("draw last_write", (wq.size() > 0) ? wq[wq.size() - 1] : 32'hFFFF_FFFF, 32'hA1);

        // Reset while the winning line is being painted
        reset_and_clear("pre_winpaint");
        goto(0, 0, "wp_nav"); step(3'b100, 1'b1, "wp_place");
        goto(0, 1, "wp_nav"); step(3'b100, 1'b1, "wp_place");
        goto(1, 0, "wp_nav"); step(3'b100, 1'b1, "wp_place");
        goto(1, 1, "wp_nav"); step(3'b100, 1'b1, "wp_place");
        goto(2, 0, "wp_nav");
        move = 3'b111;
        repeat (2) @(negedge CLK);
        move = 3'b100; new_button = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!move_ready && n < 20);
        check("wp ack_seen", {31'd0, move_ready}, 32'd1);
        new_button = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (!target_save && n < 10);
        check("wp first_write", target, 32'h05);
        check("wp game_over", {31'd0, game_over}, 32'd1);
        check("wp winner", {30'd0, winner}, 32'd1);
        move = 3'b111;
        rst = 1'b1;
        @(negedge CLK);
        check_reset_outputs("wp_rst");
        reset_and_clear("after_wp_rst");

        // Randomised games against the reference model
        for (int g = 0; g < 3; g++) begin
            reset_and_clear($sformatf("rand%0d", g));
            extra = 0;
            for (int k = 0; k < 80 && extra < 3; k++) begin
                c = codes[$urandom_range(0, 5)];
                r = ($urandom_range(0, 7) != 0);
                step(c, r, $sformatf("g%0d_k%0d", g, k));
                if (mover) extra++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have parameter P1_COLOR, default 3'b001, red mark for player 1.
REQ-002 SHALL have parameter P2_COLOR, default 3'b010, blue mark for player 2.
REQ-003 SHALL have parameter CUR_COLOR, default 3'b011, green cursor on an empty cell.
REQ-004 SHALL have parameter CUR_OCC_COLOR, default 3'b110, yellow cursor on an occupied cell.
REQ-005 SHALL have parameter WIN_COLOR, default 3'b101, cyan winning-line cells.
REQ-006 SHALL have port CLK  in  1  the only clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port move  in  3  command code: 000 up, 001 left, 011 right, 010 down, 100 place, 111 none.
REQ-009 SHALL have port new_button  in  1  a command is pending; held high until move_ready is seen.
REQ-010 SHALL have port move_ready  out  1  one-cycle acknowledge of new_button.
REQ-011 SHALL have port target  out  32  display write: [7:6] column, [5:4] row, [2:0] colour; all other bits 0.
REQ-012 SHALL have port target_save  out  1  one-cycle write strobe, qualifying target in the same cycle.
REQ-013 SHALL have port game_over  out  1  high once the game has ended (win or draw).
REQ-014 SHALL have port winner  out  2  00 none/draw, 01 player 1, 10 player 2.

Function
REQ-015 SHALL hold a 3x3 board of 2-bit cells (00 empty, 01 P1, 10 P2), a cursor (col,row, each 0..2), the current player, and a mark count 0..9.
REQ-016 SHALL run states CLEAR, PAINT_CUR, IDLE, RESTORE, PAINT, CHECK, WIN_PAINT, DONE.
REQ-017 SHALL, in CLEAR, issue 9 consecutive writes of colour 000 in row-major order, (c0,r0) first; then go to PAINT_CUR.
REQ-018 SHALL, in PAINT_CUR, write CUR_COLOR to the cursor cell, then go to IDLE.
REQ-019 SHALL, in IDLE with new_button=1, pulse move_ready for exactly one cycle and latch move.
REQ-020 SHALL not assert move_ready outside IDLE/DONE, nor on two consecutive cycles.
REQ-021 SHALL execute a latched command only while armed; armed is set on any cycle with move==111 and cleared on execution. An unarmed command is acknowledged and ignored, so a held key acts once.
REQ-022 SHALL handle up/down/left/right as follows: up decrements row, down increments row, left decrements column, right increments column; each saturates at 0 and 2 with no wrap. A saturated move issues no writes and returns to IDLE.
REQ-023 SHALL, for a real cursor move, write the old cell's mark colour in RESTORE (000, P1_COLOR or P2_COLOR), then write the new cell in PAINT (CUR_COLOR if empty, else CUR_OCC_COLOR), then return to IDLE.
REQ-024 SHALL ignore place on an occupied cell (acknowledged, no write).
REQ-025 SHALL, for place on an empty cell, store the current player's mark, increment the count and go to CHECK.
REQ-026 SHALL, in CHECK (one cycle), evaluate the 8 lines for the current player, with outcomes as follows:
  - win: set winner and game_over, then WIN_PAINT;
  - else count==9: set game_over with winner=00, RESTORE writes the mark colour, then DONE;
  - else toggle player, PAINT writes CUR_OCC_COLOR at the cursor, then IDLE.
REQ-027 SHALL, in WIN_PAINT, issue 3 consecutive WIN_COLOR writes to the winning line's cells in ascending index order; if more than one line wins, use the lowest-numbered line (rows 0-2, cols 3-5, main diagonal 6, anti-diagonal 7). Then go to DONE.
REQ-028 SHALL, in DONE, acknowledge every new_button, issue no writes, and stay until rst.
REQ-029 SHALL drive target_save low and target to 0 in every cycle without a write.
REQ-030 SHALL start the game with player 1 and the cursor at (1,1).

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear the board, count and winner, set game_over=0, move_ready=0, target_save=0, target=0, armed=0, player=P1, cursor=(1,1), state=CLEAR.
REQ-032 SHALL apply reset with priority over all events, including mid-CLEAR and mid-WIN_PAINT; after reset the CLEAR sequence restarts in full.

Structure
REQ-033 SHALL take move codes, colour codes, the cell encoding and the state enum from the shared package ttt_pkg.
REQ-034 SHALL place line evaluation in the combinational sub-module ttt_win_check (board and player in; hit and 3-bit line index out).

Verification
REQ-035 SHALL cover reset release: target_save is high on cycles 1-10, with 9 writes of colour 000 then target=32'h00000053, then IDLE.
REQ-036 SHALL cover the handshake: right accepted gives one move_ready pulse, then writes 32'h50 then 32'h93; a held right (no 111 between) is acknowledged with no further writes.
REQ-037 SHALL cover saturation: from (2,1), right gives move_ready and zero writes.
REQ-038 SHALL cover a win: P1 places (0,0),(1,0),(2,0) interleaved with P2 moves, giving winner=01, game_over=1, writes 32'h05,32'h45,32'h85; further commands are acknowledged only.
REQ-039 SHALL cover a draw: a 9-mark no-win game gives game_over=1, winner=00, and a last write of the mark colour.
REQ-040 SHALL cover rst asserted during WIN_PAINT: outputs return to reset values and the CLEAR sequence restarts.
